// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the PC operation encoding.
// Used by pc_stack and by the control unit.
package cpu_pkg;

  localparam int ADDR_W = 4;
  localparam int BUS_W  = 8;

  typedef enum logic [2:0] {
    NONE,
    INC,
    LOAD,
    JREL,
    CALL,
    RET
  } pc_op_t;

  // Fixed priority: call > ret > load > jmp_rel > inc
  function automatic pc_op_t pc_decode(
    input logic inc,
    input logic load,
    input logic jmp_rel,
    input logic call,
    input logic ret
  );
    pc_op_t op;
    op = NONE;
    case (1'b1)
      call:    op = CALL;
      ret:     op = RET;
      load:    op = LOAD;
      jmp_rel: op = JREL;
      inc:     op = INC;
      default: op = NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Parametrised LIFO for return addresses.
// Only the occupancy pointer is reset; the entries keep their contents.
module ret_stack #(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_idx  = AW'(count);
  assign rd_idx  = AW'(count - CW'(1));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;
  assign dout    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + CW'(1);
    end else if (do_pop) begin
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with relative jumps and a hardware return-address stack.
// Flags ovf/unf are sticky and do not block later operations.
module pc_stack
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int BUS_W  = cpu_pkg::BUS_W,
  parameter int DEPTH  = 4,
  parameter int SW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             load,
  input  logic             jmp_rel,
  input  logic             call,
  input  logic             ret,
  input  logic             clr_err,
  input  logic [BUS_W-1:0] bus,
  output logic [BUS_W-1:0] out,
  output logic [SW-1:0]    sp,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  pc_op_t            op;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_rel;
  logic [ADDR_W-1:0] top;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              unf_set;

  assign op      = pc_decode(inc, load, jmp_rel, call, ret);
  assign tgt     = bus[ADDR_W-1:0];
  assign pc_inc  = pc + ADDR_W'(1);
  // Offset is already ADDR_W wide, so the modulo sum equals sign-extended add
  assign pc_rel  = pc + tgt;
  assign push    = (op == CALL) && !full;
  assign pop     = (op == RET) && !empty;
  assign ovf_set = (op == CALL) && full;
  assign unf_set = (op == RET) && empty;
  assign out     = BUS_W'(pc);

  ret_stack #(
    .W     (ADDR_W),
    .DEPTH (DEPTH),
    .CW    (SW)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (top),
    .count (sp),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= ovf_set || (ovf && !clr_err);
      unf <= unf_set || (unf && !clr_err);
      unique case (op)
        CALL:    if (push) pc <= tgt;
        RET:     if (pop) pc <= top;
        LOAD:    pc <= tgt;
        JREL:    pc <= pc_rel;
        INC:     pc <= pc_inc;
        default: pc <= pc;
      endcase
    end
  end

endmodule
